// File: rtl/odd_even_sort_seq.sv
// Sequential odd-even transposition sorter.
// A vector is loaded on the input handshake. Each cycle in SORT applies one
// phase. After NUM phases the sorted vector is held until the consumer takes it.

// One compare-swap lane: x gets the element that belongs at the lower index.
module oes_cswap #(
  parameter int DW   = 8,
  parameter int MODE = 0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y
);
  logic swap;

  // Unsigned strict compare, so equal elements keep their order.
  assign swap = (MODE == 0) ? (a > b) : (a < b);
  assign x    = swap ? b : a;
  assign y    = swap ? a : b;
endmodule

module odd_even_sort_seq #(
  parameter int DW   = 8,
  parameter int NUM  = 8,
  parameter int MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW*NUM-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW*NUM-1:0] out_data,
  output logic              busy,
  output logic [15:0]       sort_cnt
);
  // Holds the value NUM without wrapping, so the count ends at NUM.
  localparam int CW = $clog2(NUM + 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              phase;
  logic [NUM-1:0][DW-1:0]     vec;
  logic [NUM-1:0][DW-1:0]     vec_phase;
  logic [NUM-2:0]             pair_act;
  logic [NUM-2:0][DW-1:0]     cs_lo;
  logic [NUM-2:0][DW-1:0]     cs_hi;
  logic                       last_phase;

  // One lane for each adjacent pair (j, j+1).
  // A lane is used on even phases when j is even, and on odd phases when j is odd.
  for (genvar j = 0; j < NUM - 1; j++) begin : g_pair
    assign pair_act[j] = (phase[0] == 1'(j % 2));
    oes_cswap #(.DW(DW), .MODE(MODE)) u_cs (
      .a (vec[j]),
      .b (vec[j+1]),
      .x (cs_lo[j]),
      .y (cs_hi[j])
    );
  end

  // Each element belongs to at most one active pair in a phase.
  // An element in no active pair, such as an unpaired end element, passes through.
  for (genvar k = 0; k < NUM; k++) begin : g_elem
    if (k == 0) begin : g_first
      assign vec_phase[k] = pair_act[0] ? cs_lo[0] : vec[0];
    end else if (k == NUM - 1) begin : g_last
      assign vec_phase[k] = pair_act[k-1] ? cs_hi[k-1] : vec[k];
    end else begin : g_mid
      assign vec_phase[k] = pair_act[k-1] ? cs_hi[k-1] :
                            (pair_act[k] ? cs_lo[k] : vec[k]);
    end
  end

  assign last_phase = (phase == CW'(NUM - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state.
  // SORT always runs NUM phases, so latency does not depend on the data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SORT;
      SORT:    if (last_phase) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, one phase per SORT cycle, count output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      vec      <= '0;
      sort_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          vec   <= in_data;
          phase <= '0;
        end
        SORT: begin
          vec   <= vec_phase;
          phase <= phase + 1'b1;
        end
        DONE: if (out_ready) sort_cnt <= sort_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SORT);
  assign out_data  = vec;
endmodule

// File: doc/odd_even_sort_seq.md
ODD_EVEN_SORT_SEQ -- requirements
Module: odd_even_sort_seq

Interface
REQ-001 SHALL have parameter DW, default 8, element width in bits.
REQ-002 SHALL have parameter NUM, default 8, element count, legal range 2..64.
REQ-003 SHALL have parameter MODE, default 0: 0 = ascending (smallest at element 0), 1 = descending (largest at element 0).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input vector offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port in_data  input  DW*NUM  packed vector; element k at bits [k*DW +: DW].
REQ-009 SHALL have port out_valid  output  1  sorted vector available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the sorted vector.
REQ-011 SHALL have port out_data  output  DW*NUM  sorted vector, same packing as in_data.
REQ-012 SHALL have port busy  output  1  high in SORT state.
REQ-013 SHALL have port sort_cnt  output  16  count of completed output handshakes.

Function
REQ-014 SHALL implement FSM states IDLE, SORT, DONE; no other reachable states.
REQ-015 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); busy SHALL equal (state == SORT).
REQ-016 Input handshake (in_valid & in_ready at an edge) SHALL load in_data into the internal vector register, clear the phase counter to 0 and move to SORT.
REQ-017 In SORT, each edge SHALL apply one odd-even transposition phase to the vector register, then increment the phase counter.
REQ-018 Even phase (counter bit 0 = 0) SHALL compare-swap pairs (0,1),(2,3),...; odd phase SHALL compare-swap pairs (1,2),(3,4),...; an unpaired end element SHALL pass unchanged.
REQ-019 Compare-swap SHALL be unsigned and strict: MODE 0 swaps only when element j > element j+1; MODE 1 swaps only when element j < element j+1; equal elements are never swapped.
REQ-020 SORT SHALL run exactly NUM phases with no early termination; the edge applying phase NUM-1 SHALL move the FSM to DONE.
REQ-021 Latency SHALL be fixed: out_valid high exactly NUM cycles after the input-handshake edge, independent of data.
REQ-022 Phase counter width SHALL be $clog2(NUM+1) bits; it SHALL not wrap during a sort.
REQ-023 out_data SHALL be driven directly from the vector register and SHALL stay stable while out_valid is high and out_ready is low.
REQ-024 In DONE, out_ready high at an edge SHALL return the FSM to IDLE and increment sort_cnt by 1, wrapping from 0xFFFF to 0x0000.
REQ-025 The block SHALL NOT accept a new input in the same cycle as the output handshake; in_ready rises the cycle after.
REQ-026 in_valid while not in IDLE SHALL be ignored; in_data changes outside a handshake SHALL not affect the register.
REQ-027 out_ready while not in DONE SHALL have no effect.
REQ-028 Result SHALL be a fully sorted permutation of the accepted input for every NUM in range.

Reset
REQ-029 rst high at an edge SHALL force state IDLE, phase counter 0, vector register 0, sort_cnt 0, overriding all handshakes.
REQ-030 After reset: in_ready = 1, out_valid = 0, busy = 0, out_data = 0, sort_cnt = 0.
REQ-031 rst asserted mid-SORT or in DONE SHALL discard the vector with no output handshake and no sort_cnt increment.

Verification
REQ-032 DW=8, NUM=8, MODE=0: elements 0..7 = 7,6,5,4,3,2,1,0 -> out_data elements 0,1,...,7; out_valid exactly 8 cycles after accept; busy high those 8 cycles.
REQ-033 MODE=1, elements 0..7 = 3,9,3,0,255,1,9,2 -> elements 255,9,9,3,3,2,1,0; sort_cnt 0 -> 1 after handshake.
REQ-034 Hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, second in_valid ignored; release -> IDLE next cycle, in_ready=1 the cycle after the output handshake.
REQ-035 rst pulse on 4th SORT cycle -> next cycle in_ready=1, out_data=0, sort_cnt unchanged-to-0, out_valid never asserts for that vector.
REQ-036 NUM=5, MODE=0, input 4,4,1,0,2 -> 0,1,2,4,4 after 5 cycles; already-sorted input still takes 5 cycles.
REQ-037 65536 back-to-back sorts with random data vs reference model -> all match; sort_cnt wraps to 0x0000.
